// File: rtl/bp_cce_pkg.sv
// bp_cce_pkg
//   Shared CCE types. bp_cce_spec_s holds the per-way-group speculation
//   metadata. bp_cce_spec_field_e names the bit positions of the
//   tracker's per-field write enable. spec_merge applies such a masked write.
package bp_cce_pkg;

    typedef struct packed {
        logic       spec;
        logic       squash;
        logic       fwd_mod;
        logic [2:0] state;
    } bp_cce_spec_s;

    // Bit positions in w_field_v_i ({state, fwd_mod, squash, spec})
    typedef enum logic [1:0] {
        e_spec_field_spec    = 2'd0,
        e_spec_field_squash  = 2'd1,
        e_spec_field_fwd_mod = 2'd2,
        e_spec_field_state   = 2'd3
    } bp_cce_spec_field_e;

    localparam int unsigned spec_width_lp = $bits(bp_cce_spec_s);

    function automatic bp_cce_spec_s spec_merge(input bp_cce_spec_s old_spec,
                                                input bp_cce_spec_s new_spec,
                                                input logic [3:0]   field_v);
        bp_cce_spec_s merged;
        merged = old_spec;
        if (field_v[e_spec_field_spec])    merged.spec    = new_spec.spec;
        if (field_v[e_spec_field_squash])  merged.squash  = new_spec.squash;
        if (field_v[e_spec_field_fwd_mod]) merged.fwd_mod = new_spec.fwd_mod;
        if (field_v[e_spec_field_state])   merged.state   = new_spec.state;
        return merged;
    endfunction

endpackage

// File: rtl/bp_cce_wg_hash.sv
// bp_cce_wg_hash
//   Maps a line address to a way-group index for this CCE.
//   addr_i is a line address: the low lg(num_cce_p) bits select the owning
//   CCE bank and the next lg(num_way_groups_p) bits index the way group.
//   With a power-of-two bank count the bank hash reduces to this bit split,
//   so it is done inline. The way-group field is bit-reversed to match the
//   directory's way-group numbering. bypass_hash_i takes the low address
//   bits directly as the index (ucode addressing way groups by number).
//   num_cce_p and num_way_groups_p must be powers of two.
// Ports
//   addr_i         in   address
//   bypass_hash_i  in   use addr_i[lg_wg-1:0] as the way group
//   wg_o           out  way-group index
module bp_cce_wg_hash #(
    parameter int num_way_groups_p = 8,
    parameter int num_cce_p        = 1,
    parameter int addr_width_p     = 16
) (
    input  logic [addr_width_p-1:0]             addr_i,
    input  logic                                bypass_hash_i,
    output logic [$clog2(num_way_groups_p)-1:0] wg_o
);

    localparam int lg_wg_lp  = $clog2(num_way_groups_p);
    localparam int lg_cce_lp = (num_cce_p > 1) ? $clog2(num_cce_p) : 0;

    logic [lg_wg_lp-1:0] w_idx;
    logic [lg_wg_lp-1:0] w_rev;
    logic                w_unused;

    assign w_idx = addr_i[lg_cce_lp +: lg_wg_lp];

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < lg_wg_lp; i++) begin
            w_rev[i] = w_idx[lg_wg_lp-1-i];
        end
    end

    assign wg_o = bypass_hash_i ? addr_i[lg_wg_lp-1:0] : w_rev;

    // Upper address bits do not participate in the index.
    assign w_unused = ^addr_i;

endmodule

// File: rtl/bp_cce_spec_tracker.sv
// bp_cce_spec_tracker
//   Per-way-group speculation metadata store with a pending speculative
//   response counter per way group and several asynchronous read ports.
//   A counter stepping 1->0 auto-resolves its entry (clears spec, squash);
//   explicit field writes in the same cycle take precedence.
// Build option
//   BP_CCE_SPEC_FWD_EN : when defined, a valid read returns the next-state
//                        value (write/inc/dec forwarding); otherwise reads
//                        return registered state.
// Ports
//   clk_i, reset_n_i           clock, async active-low reset
//   w_v_i/w_addr_i/...         masked field write (w_field_v_i per field)
//   inc_v_i/inc_addr_i         speculative request issued (counter +1)
//   dec_v_i/dec_addr_i         speculative response returned (counter -1)
//   r_v_i/r_addr_i/...         per-port read request
//   spec_o, pend_o, v_o        per-port read data
//   idle_o                     all counters zero
//   err_o                      sticky overflow/underflow
module bp_cce_spec_tracker
    import bp_cce_pkg::*;
#(
    parameter int num_way_groups_p = 8,
    parameter int num_cce_p        = 2,
    parameter int addr_width_p     = 16,
    parameter int num_rd_ports_p   = 2,
    parameter int pend_width_p     = 3
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic                                      w_v_i,
    input  logic [addr_width_p-1:0]                   w_addr_i,
    input  logic                                      w_addr_bypass_hash_i,
    input  logic [3:0]                                w_field_v_i,
    input  bp_cce_spec_s                              spec_i,
    input  logic                                      inc_v_i,
    input  logic [addr_width_p-1:0]                   inc_addr_i,
    input  logic                                      dec_v_i,
    input  logic [addr_width_p-1:0]                   dec_addr_i,
    input  logic [num_rd_ports_p-1:0]                 r_v_i,
    input  logic [num_rd_ports_p*addr_width_p-1:0]    r_addr_i,
    input  logic [num_rd_ports_p-1:0]                 r_addr_bypass_hash_i,
    output logic [num_rd_ports_p*spec_width_lp-1:0]   spec_o,
    output logic [num_rd_ports_p*pend_width_p-1:0]    pend_o,
    output logic [num_rd_ports_p-1:0]                 v_o,
    output logic                                      idle_o,
    output logic                                      err_o
);

    localparam int                      lg_wg_lp    = $clog2(num_way_groups_p);
    localparam logic [pend_width_p-1:0] pend_max_lp = '1;
    localparam logic [pend_width_p-1:0] pend_one_lp = pend_width_p'(1);

    logic [lg_wg_lp-1:0]          w_w_wg;
    logic [lg_wg_lp-1:0]          w_inc_wg;
    logic [lg_wg_lp-1:0]          w_dec_wg;
    logic [lg_wg_lp-1:0]          w_r_wg [num_rd_ports_p];

    logic [num_way_groups_p-1:0]  w_inc_hit;
    logic [num_way_groups_p-1:0]  w_dec_hit;
    logic [num_way_groups_p-1:0]  w_wr_hit;

    bp_cce_spec_s                 r_spec   [num_way_groups_p];
    logic [pend_width_p-1:0]      r_pend   [num_way_groups_p];
    logic                         r_err;
    bp_cce_spec_s                 w_spec_n [num_way_groups_p];
    logic [pend_width_p-1:0]      w_pend_n [num_way_groups_p];
    logic                         w_err_n;
    logic                         w_idle;
    logic                         w_fwd_en;

    bp_cce_wg_hash #(
        .num_way_groups_p (num_way_groups_p),
        .num_cce_p        (num_cce_p),
        .addr_width_p     (addr_width_p)
    ) u_hash_w (
        .addr_i        (w_addr_i),
        .bypass_hash_i (w_addr_bypass_hash_i),
        .wg_o          (w_w_wg)
    );

    bp_cce_wg_hash #(
        .num_way_groups_p (num_way_groups_p),
        .num_cce_p        (num_cce_p),
        .addr_width_p     (addr_width_p)
    ) u_hash_inc (
        .addr_i        (inc_addr_i),
        .bypass_hash_i (1'b0),
        .wg_o          (w_inc_wg)
    );

    bp_cce_wg_hash #(
        .num_way_groups_p (num_way_groups_p),
        .num_cce_p        (num_cce_p),
        .addr_width_p     (addr_width_p)
    ) u_hash_dec (
        .addr_i        (dec_addr_i),
        .bypass_hash_i (1'b0),
        .wg_o          (w_dec_wg)
    );

    always_comb begin
        w_inc_hit           = '0;
        w_dec_hit           = '0;
        w_wr_hit            = '0;
        w_inc_hit[w_inc_wg] = inc_v_i;
        w_dec_hit[w_dec_wg] = dec_v_i;
        w_wr_hit[w_w_wg]    = w_v_i;
    end

    // Next state for every way group. Inc and dec on one group cancel, so
    // only an unmatched step can overflow, underflow or auto-resolve.
    always_comb begin
        w_err_n = r_err;
        for (int g = 0; g < num_way_groups_p; g++) begin
            w_pend_n[g] = r_pend[g];
            w_spec_n[g] = r_spec[g];
            if (w_inc_hit[g] && !w_dec_hit[g]) begin
                if (r_pend[g] == pend_max_lp) begin
                    w_err_n = 1'b1;
                end else begin
                    w_pend_n[g] = r_pend[g] + pend_one_lp;
                end
            end
            if (w_dec_hit[g] && !w_inc_hit[g]) begin
                if (r_pend[g] == '0) begin
                    w_err_n = 1'b1;
                end else begin
                    w_pend_n[g] = r_pend[g] - pend_one_lp;
                end
                if (r_pend[g] == pend_one_lp) begin
                    w_spec_n[g].spec   = 1'b0;
                    w_spec_n[g].squash = 1'b0;
                end
            end
            if (w_wr_hit[g]) begin
                w_spec_n[g] = spec_merge(w_spec_n[g], spec_i, w_field_v_i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int g = 0; g < num_way_groups_p; g++) begin
                r_spec[g] <= '0;
                r_pend[g] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int g = 0; g < num_way_groups_p; g++) begin
                r_spec[g] <= w_spec_n[g];
                r_pend[g] <= w_pend_n[g];
            end
            r_err <= w_err_n;
        end
    end

`ifdef BP_CCE_SPEC_FWD_EN
    // Forwarded data is suppressed while reset is held so reads stay zero.
    assign w_fwd_en = reset_n_i;
`else
    assign w_fwd_en = 1'b0;
`endif

    for (genvar p = 0; p < num_rd_ports_p; p++) begin : g_rd
        bp_cce_wg_hash #(
            .num_way_groups_p (num_way_groups_p),
            .num_cce_p        (num_cce_p),
            .addr_width_p     (addr_width_p)
        ) u_hash_r (
            .addr_i        (r_addr_i[p*addr_width_p +: addr_width_p]),
            .bypass_hash_i (r_addr_bypass_hash_i[p]),
            .wg_o          (w_r_wg[p])
        );

        // Next state equals registered state for untouched groups, so a
        // valid read can always select the next-state view when forwarding.
        assign spec_o[p*spec_width_lp +: spec_width_lp] =
            (w_fwd_en && r_v_i[p]) ? w_spec_n[w_r_wg[p]] : r_spec[w_r_wg[p]];
        assign pend_o[p*pend_width_p +: pend_width_p] =
            (w_fwd_en && r_v_i[p]) ? w_pend_n[w_r_wg[p]] : r_pend[w_r_wg[p]];
    end

    always_comb begin
        w_idle = 1'b1;
        for (int g = 0; g < num_way_groups_p; g++) begin
            if (r_pend[g] != '0) w_idle = 1'b0;
        end
    end

    assign v_o    = r_v_i;
    assign idle_o = w_idle;
    assign err_o  = r_err;

endmodule

// File: tb/tb_bp_cce_spec_tracker.sv
// tb_bp_cce_spec_tracker
//   Directed bench for bp_cce_spec_tracker with 8 way groups, 2 CCEs,
//   16-bit addresses, 2 read ports, 3-bit counters. Hashed addresses used
//   below (index = bit-reverse of addr[3:1]): 0x4->wg2, 0x6->wg6, 0x8->wg1,
//   0xC/0x10C->wg3, 0xE->wg7. Reads by way-group number use the bypass.
module tb_bp_cce_spec_tracker;
    import bp_cce_pkg::*;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         w_v_i;
    logic [15:0]  w_addr_i;
    logic         w_addr_bypass_hash_i;
    logic [3:0]   w_field_v_i;
    bp_cce_spec_s spec_i;
    logic         inc_v_i;
    logic [15:0]  inc_addr_i;
    logic         dec_v_i;
    logic [15:0]  dec_addr_i;
    logic [1:0]   r_v_i;
    logic [31:0]  r_addr_i;
    logic [1:0]   r_addr_bypass_hash_i;
    logic [11:0]  spec_o;
    logic [5:0]   pend_o;
    logic [1:0]   v_o;
    logic         idle_o;
    logic         err_o;

    int n_cmp;
    int n_err;

    bp_cce_spec_tracker #(
        .num_way_groups_p (8),
        .num_cce_p        (2),
        .addr_width_p     (16),
        .num_rd_ports_p   (2),
        .pend_width_p     (3)
    ) dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .w_v_i                (w_v_i),
        .w_addr_i             (w_addr_i),
        .w_addr_bypass_hash_i (w_addr_bypass_hash_i),
        .w_field_v_i          (w_field_v_i),
        .spec_i               (spec_i),
        .inc_v_i              (inc_v_i),
        .inc_addr_i           (inc_addr_i),
        .dec_v_i              (dec_v_i),
        .dec_addr_i           (dec_addr_i),
        .r_v_i                (r_v_i),
        .r_addr_i             (r_addr_i),
        .r_addr_bypass_hash_i (r_addr_bypass_hash_i),
        .spec_o               (spec_o),
        .pend_o               (pend_o),
        .v_o                  (v_o),
        .idle_o               (idle_o),
        .err_o                (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int p, input logic [15:0] a, input logic byp, input logic v);
        r_addr_i[p*16 +: 16]    = a;
        r_addr_bypass_hash_i[p] = byp;
        r_v_i[p]                = v;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [7:0] spec_at(input int p);
        return 8'(spec_o[p*6 +: 6]);
    endfunction

    function automatic logic [7:0] pend_at(input int p);
        return 8'(pend_o[p*3 +: 3]);
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n_i = 1'b1;
        w_v_i = 1'b0; w_addr_i = '0; w_addr_bypass_hash_i = 1'b0; w_field_v_i = '0;
        spec_i = '0;
        inc_v_i = 1'b0; inc_addr_i = '0; dec_v_i = 1'b0; dec_addr_i = '0;
        r_v_i = '0; r_addr_i = '0; r_addr_bypass_hash_i = '0;
        #1 reset_n_i = 1'b0;

        // Reset state on every way group, both ports
        @(posedge clk_i);
        #1;
        for (int g = 0; g < 8; g++) begin
            rd(0, 16'(g), 1'b1, 1'b1);
            rd(1, 16'(7 - g), 1'b1, 1'b0);
            #1;
            chk("rst_spec_p0", spec_at(0), 8'h00);
            chk("rst_pend_p0", pend_at(0), 8'h00);
            chk("rst_spec_p1", spec_at(1), 8'h00);
            chk("rst_pend_p1", pend_at(1), 8'h00);
        end
        chk("rst_idle", 8'(idle_o), 8'h01);
        chk("rst_err", 8'(err_o), 8'h00);
        chk("v_o_follows", 8'(v_o), 8'h01);

        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();

        // Masked write of spec only on wg5, read same cycle
        w_v_i = 1'b1; w_addr_i = 16'h0005; w_addr_bypass_hash_i = 1'b1;
        w_field_v_i = 4'b0001; spec_i = 6'b111111;
        rd(0, 16'h0005, 1'b1, 1'b1);
        rd(1, 16'h0005, 1'b1, 1'b0);
        #1;
`ifdef BP_CCE_SPEC_FWD_EN
        chk("wr_same_cycle_p0", spec_at(0), 8'h20);
`else
        chk("wr_same_cycle_p0", spec_at(0), 8'h00);
`endif
        chk("wr_same_cycle_p1_invalid", spec_at(1), 8'h00);
        tick();
        w_v_i = 1'b0;
        #1;
        chk("wr_next_p0", spec_at(0), 8'h20);
        chk("wr_next_p1", spec_at(1), 8'h20);

        // wg3: set spec+squash and inc, inc again, then two decs
        w_v_i = 1'b1; w_addr_i = 16'h0003; w_field_v_i = 4'b0011; spec_i = 6'b110000;
        inc_v_i = 1'b1; inc_addr_i = 16'h000C;
        tick();
        w_v_i = 1'b0;
        tick();
        inc_v_i = 1'b0;
        rd(0, 16'h010C, 1'b0, 1'b1);
        rd(1, 16'h0003, 1'b1, 1'b1);
        #1;
        chk("wg3_pend2_p1", pend_at(1), 8'h02);
        chk("wg3_pend2_hashed_p0", pend_at(0), 8'h02);
        chk("wg3_not_idle", 8'(idle_o), 8'h00);
        dec_v_i = 1'b1; dec_addr_i = 16'h000C;
        tick();
        dec_v_i = 1'b0;
        #1;
        chk("wg3_pend1", pend_at(1), 8'h01);
        chk("wg3_spec_kept", spec_at(1), 8'h30);
        dec_v_i = 1'b1;
        #1;
`ifdef BP_CCE_SPEC_FWD_EN
        chk("wg3_fwd_pend", pend_at(1), 8'h00);
        chk("wg3_fwd_spec", spec_at(1), 8'h00);
`else
        chk("wg3_fwd_pend", pend_at(1), 8'h01);
        chk("wg3_fwd_spec", spec_at(1), 8'h30);
`endif
        tick();
        dec_v_i = 1'b0;
        #1;
        chk("wg3_resolved_pend", pend_at(1), 8'h00);
        chk("wg3_resolved_spec", spec_at(1), 8'h00);
        chk("wg3_idle", 8'(idle_o), 8'h01);

        // wg2: count to 4, then simultaneous inc+dec
        inc_v_i = 1'b1; inc_addr_i = 16'h0004;
        repeat (4) tick();
        inc_v_i = 1'b0;
        rd(1, 16'h0002, 1'b1, 1'b0);
        #1;
        chk("wg2_pend4", pend_at(1), 8'h04);
        inc_v_i = 1'b1; dec_v_i = 1'b1; dec_addr_i = 16'h0004;
        tick();
        inc_v_i = 1'b0; dec_v_i = 1'b0;
        #1;
        chk("wg2_incdec_pend", pend_at(1), 8'h04);
        chk("wg2_incdec_err", 8'(err_o), 8'h00);

        // Overflow at 7
        inc_v_i = 1'b1;
        repeat (3) tick();
        #1;
        chk("wg2_pend7", pend_at(1), 8'h07);
        chk("wg2_pend7_err", 8'(err_o), 8'h00);
        tick();
        inc_v_i = 1'b0;
        #1;
        chk("ovf_pend_sat", pend_at(1), 8'h07);
        chk("ovf_err", 8'(err_o), 8'h01);
        tick();
        chk("ovf_err_held", 8'(err_o), 8'h01);

        // Reset pulse between edges clears counters and err
        #1 reset_n_i = 1'b0;
        #2;
        chk("pulse_pend", pend_at(1), 8'h00);
        chk("pulse_err", 8'(err_o), 8'h00);
        chk("pulse_idle", 8'(idle_o), 8'h01);
        reset_n_i = 1'b1;
        tick();

        // Underflow on fresh wg6
        dec_v_i = 1'b1; dec_addr_i = 16'h0006;
        rd(1, 16'h0006, 1'b1, 1'b1);
        tick();
        dec_v_i = 1'b0;
        #1;
        chk("udf_pend", pend_at(1), 8'h00);
        chk("udf_err", 8'(err_o), 8'h01);

        // wg1: set squash with inc, then final dec while writing spec
        inc_v_i = 1'b1; inc_addr_i = 16'h0008;
        w_v_i = 1'b1; w_addr_i = 16'h0001; w_addr_bypass_hash_i = 1'b1;
        w_field_v_i = 4'b0010; spec_i = 6'b010000;
        tick();
        inc_v_i = 1'b0; w_v_i = 1'b0;
        rd(1, 16'h0001, 1'b1, 1'b1);
        #1;
        chk("wg1_pend1", pend_at(1), 8'h01);
        chk("wg1_squash", spec_at(1), 8'h10);
        dec_v_i = 1'b1; dec_addr_i = 16'h0008;
        w_v_i = 1'b1; w_field_v_i = 4'b0001; spec_i = 6'b100000;
        #1;
`ifdef BP_CCE_SPEC_FWD_EN
        chk("wg1_fwd_spec", spec_at(1), 8'h20);
        chk("wg1_fwd_pend", pend_at(1), 8'h00);
`else
        chk("wg1_fwd_spec", spec_at(1), 8'h10);
        chk("wg1_fwd_pend", pend_at(1), 8'h01);
`endif
        tick();
        dec_v_i = 1'b0; w_v_i = 1'b0;
        #1;
        chk("wg1_write_wins_spec", spec_at(1), 8'h20);
        chk("wg1_pend0", pend_at(1), 8'h00);
        chk("wg1_idle", 8'(idle_o), 8'h01);
        chk("err_still_set", 8'(err_o), 8'h01);

        // Async reset between edges, then in-reset inc is discarded
        #2 reset_n_i = 1'b0;
        rd(0, 16'h0008, 1'b0, 1'b1);
        #1;
        chk("async_rst_spec_p1", spec_at(1), 8'h00);
        chk("async_rst_spec_p0", spec_at(0), 8'h00);
        chk("async_rst_err", 8'(err_o), 8'h00);
        chk("async_rst_idle", 8'(idle_o), 8'h01);
        inc_v_i = 1'b1; inc_addr_i = 16'h000E;
        rd(0, 16'h0007, 1'b1, 1'b1);
        tick();
        chk("in_rst_inc_dropped", pend_at(0), 8'h00);
        reset_n_i = 1'b1;
        tick();
        inc_v_i = 1'b0;
        #1;
        chk("first_edge_inc", pend_at(0), 8'h01);
        chk("first_edge_not_idle", 8'(idle_o), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
